// File: rtl/keyed_wire_mux_lock.sv
// keyed_wire_mux_lock
//   NUM_CH independent keyed muxes. Each channel picks one of 2**SEL_W
//   candidate wires using SEL_W bits of a committed key and drives a
//   registered output. The key is shifted serially, MSB first, into a shadow
//   register and then committed atomically. Until a key is committed, every
//   output is held at 0.
//
// Ports
//   CK          clock, rising edge
//   RST         asynchronous reset, active-high
//   CAND        candidate wires; channel c candidate k is bit c*2**SEL_W+k
//   KEY_SI      serial key bit (sampled only while KEY_SE is high)
//   KEY_SE      shift enable
//   KEY_COMMIT  pulse: copy the shadow key into the active key
//   KEY_CLR     pulse: clear both keys and the error flag, return to LOCKED
//   MUX_O       registered keyed mux outputs
//   KEY_VALID   high while a committed key is in use
//   KEY_ERR     sticky flag: a commit arrived before a full key was shifted
//   SHIFT_CNT   bits shifted since the last commit or clear (saturates)

// Single channel: registered select of one candidate, forced to 0 when disabled.
module keyed_wire_mux_lane #(
  parameter int SEL_W = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [2**SEL_W-1:0] cand,
  input  logic [SEL_W-1:0]    sel,
  output logic                q
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= 1'b0;
    else     q <= en ? cand[sel] : 1'b0;
  end
endmodule

module keyed_wire_mux_lock #(
  parameter  int NUM_CH   = 4,
  parameter  int SEL_W    = 2,
  localparam int NUM_CAND = 2**SEL_W,
  localparam int KEY_LEN  = NUM_CH*SEL_W,
  localparam int CNT_W    = $clog2(KEY_LEN+1)
) (
  input  logic                       CK,
  input  logic                       RST,
  input  logic [NUM_CH*NUM_CAND-1:0] CAND,
  input  logic                       KEY_SI,
  input  logic                       KEY_SE,
  input  logic                       KEY_COMMIT,
  input  logic                       KEY_CLR,
  output logic [NUM_CH-1:0]          MUX_O,
  output logic                       KEY_VALID,
  output logic                       KEY_ERR,
  output logic [CNT_W-1:0]           SHIFT_CNT
);
  typedef enum logic {LOCKED = 1'b0, ACTIVE = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [KEY_LEN-1:0] key_sr_q, key_sr_d;
  logic [KEY_LEN-1:0] key_reg_q, key_reg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic               full;
  logic               mux_en;

  assign full = (cnt_q == CNT_W'(KEY_LEN));

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state_q   <= LOCKED;
      key_sr_q  <= '0;
      key_reg_q <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      key_sr_q  <= key_sr_d;
      key_reg_q <= key_reg_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  // Priority CLR > COMMIT > SE. A commit (good or early) swallows a
  // simultaneous shift, so the count after a good commit is 0, not 1.
  always_comb begin
    state_d   = state_q;
    key_sr_d  = key_sr_q;
    key_reg_d = key_reg_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    if (KEY_CLR) begin
      state_d   = LOCKED;
      key_sr_d  = '0;
      key_reg_d = '0;
      cnt_d     = '0;
      err_d     = 1'b0;
    end else if (KEY_COMMIT) begin
      if (full) begin
        state_d   = ACTIVE;
        key_reg_d = key_sr_q;
        cnt_d     = '0;
        err_d     = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end else if (KEY_SE) begin
      key_sr_d = {key_sr_q[KEY_LEN-2:0], KEY_SI};
      if (!full) cnt_d = cnt_q + 1'b1;
    end
  end

  // Outputs follow the current (pre-edge) state and key, so a commit shows
  // its selection one cycle after the commit edge and every channel switches
  // together. A clear zeroes the outputs on its own edge.
  assign mux_en = (state_q == ACTIVE) && !KEY_CLR;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    keyed_wire_mux_lane #(.SEL_W(SEL_W)) u_lane (
      .clk  (CK),
      .rst  (RST),
      .en   (mux_en),
      .cand (CAND[c*NUM_CAND +: NUM_CAND]),
      .sel  (key_reg_q[c*SEL_W +: SEL_W]),
      .q    (MUX_O[c])
    );
  end

  assign KEY_VALID = (state_q == ACTIVE);
  assign KEY_ERR   = err_q;
  assign SHIFT_CNT = cnt_q;
endmodule

// File: doc/keyed_wire_mux_lock.md
Name: keyed_wire_mux_lock

Overview:
- Parametrised successor to the single two-bit-key dummy-wire mux used in the locked c17 netlists.
- NUM_CH independent keyed muxes; each selects one of 2**SEL_W candidate internal wires and drives a locked gate input.
- Key is loaded serially into a shadow register, then committed atomically to the active key.
- Outputs are held at 0 until a valid key has been committed, so an unkeyed circuit never exposes functional wires.

Parameters:
- NUM_CH, 4: number of keyed mux channels.
- SEL_W, 2: key bits per channel; each channel has 2**SEL_W candidates.
- KEY_LEN, NUM_CH*SEL_W (derived; do not override): total key length.
- CNT_W, $clog2(KEY_LEN+1) (derived): width of the shift counter.

Ports:
- CK  input  1  clock, rising edge.
- RST  input  1  asynchronous reset, active-high.
- CAND  input  NUM_CH*2**SEL_W  candidate wires; channel c candidate k is bit c*2**SEL_W+k.
- KEY_SI  input  1  serial key bit, MSB first.
- KEY_SE  input  1  shift enable.
- KEY_COMMIT  input  1  single-cycle pulse; copies shadow key to active key.
- KEY_CLR  input  1  single-cycle pulse; clears the keys and returns to LOCKED.
- MUX_O  output  NUM_CH  registered keyed mux outputs.
- KEY_VALID  output  1  high while in ACTIVE.
- KEY_ERR  output  1  sticky flag for an early commit.
- SHIFT_CNT  output  CNT_W  number of bits shifted since the last commit or clear.

Behaviour:
- Clock and reset: single clock CK. RST is asynchronous and active-high.
- Reset values:
  - State = LOCKED.
  - key_sr = 0, key_reg = 0, SHIFT_CNT = 0.
  - MUX_O = 0, KEY_VALID = 0, KEY_ERR = 0.
- States:
  - LOCKED (0): no committed key.
  - ACTIVE (1): a committed key is in use.
- Control priority each cycle: KEY_CLR > KEY_COMMIT > KEY_SE. A lower-priority input is ignored in any cycle where a higher one is asserted.
- KEY_CLR (any state):
  - Clears key_sr, key_reg, SHIFT_CNT and KEY_ERR.
  - Next state = LOCKED; MUX_O = 0 from the following edge.
- KEY_SE:
  - key_sr <= {key_sr[KEY_LEN-2:0], KEY_SI}.
  - SHIFT_CNT increments and saturates at KEY_LEN. Extra shifts keep shifting, so the last KEY_LEN bits win.
  - Allowed in both states. In ACTIVE, shifting changes the shadow register only; key_reg and MUX_O are unaffected.
- KEY_COMMIT with SHIFT_CNT == KEY_LEN:
  - key_reg <= key_sr; SHIFT_CNT <= 0; KEY_ERR <= 0.
  - State <= ACTIVE; KEY_VALID = 1 from the next edge.
- KEY_COMMIT with SHIFT_CNT < KEY_LEN:
  - Ignored: key_reg, state and SHIFT_CNT are unchanged.
  - KEY_ERR <= 1, sticky until KEY_CLR, RST or a successful commit.
- Key mapping: channel c select = key_reg[c*SEL_W +: SEL_W]. The first bit shifted in lands at key_reg[KEY_LEN-1], i.e. the channel NUM_CH-1 MSB.
- Datapath:
  - In ACTIVE: MUX_O[c] <= CAND[c*2**SEL_W + sel_c] every cycle, one-cycle latency from CAND.
  - In LOCKED: MUX_O <= 0.
  - On the commit edge, MUX_O still reflects the old state; the new key's selection appears one cycle after the commit edge.
- Re-commit while ACTIVE: the new key replaces the old one atomically. There is no cycle with mixed old and new selects.
- RST mid-shift or mid-operation: all state is lost immediately (asynchronous). After release the block is in LOCKED and needs a full KEY_LEN shift plus commit.
- KEY_SI is sampled only when KEY_SE is high.

Test Plan:
- Reset/locked: assert RST, then release; drive CAND = all ones → MUX_O = 4'b0000, KEY_VALID = 0, KEY_ERR = 0, SHIFT_CNT = 0 for 10 cycles.
- Basic load: shift 8'b11_10_01_00 MSB first, pulse KEY_COMMIT; CAND = 16'b1000_0100_0010_0001 → MUX_O = 4'b1111 two edges after the commit, KEY_VALID = 1. Then CAND = 16'h0001 → MUX_O = 4'b0001 one cycle later.
- Early commit: shift 5 bits, pulse KEY_COMMIT → KEY_ERR = 1, KEY_VALID = 0, SHIFT_CNT = 5. Shift 3 more bits and commit → KEY_ERR = 0, KEY_VALID = 1.
- Shadow isolation: in ACTIVE with key 8'hE4, shift 8'h00 without committing → MUX_O is unchanged. Then commit → all channels select candidate 0 from the next cycle.
- Priority: assert KEY_CLR, KEY_COMMIT and KEY_SE together in ACTIVE → next state LOCKED, SHIFT_CNT = 0, MUX_O = 0. Assert KEY_COMMIT and KEY_SE together with SHIFT_CNT = 8 → commit happens and SHIFT_CNT = 0, not 1.
- Async reset: assert RST between clock edges during a shift → all outputs reach 0 before the next CK edge, and state is LOCKED.
